// File: rtl/mdu_ctrl_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// controller states and small decode helpers.
package mdu_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned MDUOP_W = 3;

    typedef enum logic [MDUOP_W-1:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_S_IDLE = 2'd0,
        MDU_S_CALC = 2'd1,
        MDU_S_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_signed(input logic [MDUOP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input logic [MDUOP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_ctrl_if #(
    parameter int unsigned W = mdu_ctrl_pkg::WORD_W
);
    logic                               start;
    logic [mdu_ctrl_pkg::MDUOP_W-1:0]   mdu_op;
    logic [W-1:0]                       op1;
    logic [W-1:0]                       op2;
    logic                               cancel;
    logic                               busy;
    logic                               done;
    logic [W-1:0]                       hi;
    logic [W-1:0]                       lo;

    modport master (
        output start, mdu_op, op1, op2, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mdu_op, op1, op2, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl_step.sv
// One combinational iteration: shift-add multiply step or restoring divide
// step on a shared 2W-bit accumulator {upper, lower}.
module mdu_step #(
    parameter int unsigned W = 32
) (
    input  logic [2*W-1:0] acc_i,
    input  logic [W-1:0]   opnd_i,
    input  logic           is_div_i,
    output logic [2*W-1:0] acc_o
);

    logic [W:0] sum;
    logic [W:0] part_rem;
    logic [W:0] diff;

    always_comb begin
        // Multiply: lower half holds the remaining multiplier bits; the carry
        // out of the add becomes the new MSB as the pair shifts right.
        sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);

        // Divide: shift the remainder/dividend pair left into a W+1 bit
        // partial remainder and keep the trial subtraction if it stays positive.
        part_rem = acc_i[2*W-1:W-1];
        diff     = part_rem - {1'b0, opnd_i};

        if (is_div_i) begin
            if (diff[W]) begin
                acc_o = {part_rem[W-1:0], acc_i[W-2:0], 1'b0};
            end else begin
                acc_o = {diff[W-1:0], acc_i[W-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences 32 iterations through
// mdu_step, applies sign correction and handles MTHI/MTLO and cancel.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned W     = WORD_W,
    parameter int unsigned CNT_W = 5
) (
    input logic         clk,
    input logic         rst_n,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;

    logic [2*W-1:0]   acc_step;
    logic             op_signed, op_div;
    logic             a_neg, b_neg;
    logic [W-1:0]     a_abs, b_abs;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo, rem;

    mdu_step #(.W(W)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        op_signed = op_is_signed(bus.mdu_op);
        op_div    = op_is_div(bus.mdu_op);
        a_neg     = op_signed & bus.op1[W-1];
        b_neg     = op_signed & bus.op2[W-1];
        a_abs     = a_neg ? (~bus.op1 + 1'b1) : bus.op1;
        b_abs     = b_neg ? (~bus.op2 + 1'b1) : bus.op2;
        prod      = acc_q;
        quo       = acc_q[W-1:0];
        rem       = acc_q[2*W-1:W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            MDU_S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    case (bus.mdu_op)
                        MDU_MTHI: hi_d = bus.op1;
                        MDU_MTLO: lo_d = bus.op1;
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            is_div_d = op_div;
                            neg_d    = a_neg ^ b_neg;
                            rneg_d   = a_neg;
                            cnt_d    = '0;
                            // Divide by zero bypasses CALC; the raw dividend
                            // rides in the accumulator so FIX can place it in HI.
                            if (op_div && (bus.op2 == '0)) begin
                                dz_d    = 1'b1;
                                acc_d   = {{W{1'b0}}, bus.op1};
                                state_d = MDU_S_FIX;
                            end else begin
                                dz_d    = 1'b0;
                                opnd_d  = op_div ? b_abs : a_abs;
                                acc_d   = {{W{1'b0}}, (op_div ? a_abs : b_abs)};
                                state_d = MDU_S_CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            MDU_S_CALC: begin
                if (bus.cancel) begin
                    state_d = MDU_S_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(W-1)) begin
                        state_d = MDU_S_FIX;
                    end
                end
            end

            MDU_S_FIX: begin
                state_d = MDU_S_IDLE;
                if (!bus.cancel) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        lo_d = '1;
                        hi_d = acc_q[W-1:0];
                    end else if (is_div_q) begin
                        lo_d = neg_q  ? (~quo + 1'b1) : quo;
                        hi_d = rneg_q ? (~rem + 1'b1) : rem;
                    end else begin
                        {hi_d, lo_d} = neg_q ? (~prod + 1'b1) : prod;
                    end
                end
            end

            default: state_d = MDU_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q != MDU_S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized
// mul/div traffic checked against 64-bit arithmetic.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] model_hi, model_lo;

    mdu_ctrl_if #(.W(32)) bus ();

    mdu_ctrl #(.W(32), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero
    // and the remainder follows the dividend, as the architecture requires.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output int ebusy);
        longint sa, sb, sq, sr;
        logic [63:0] p, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ebusy = 33;
        eh = 'x; el = 'x;
        case (op)
            MDU_MULT:  begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            MDU_MULTU: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            MDU_DIV: begin
                if (b == 0) begin el = '1; eh = a; ebusy = 1; end
                else begin
                    sq = sa / sb; sr = sa % sb;
                    uq = 64'(sq); ur = 64'(sr);
                    el = uq[31:0]; eh = ur[31:0];
                end
            end
            MDU_DIVU: begin
                if (b == 0) begin el = '1; eh = a; ebusy = 1; end
                else begin
                    uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
                    el = uq[31:0]; eh = ur[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Issues one operation and observes it; performs no comparisons itself.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output int done_cnt,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = op; bus.op1 = a; bus.op2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        busy_cyc = 0; done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) done_cnt++;
            if (done_cnt > 0 && !bus.done) break;
        end
        hi_o = bus.hi; lo_o = bus.lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP; bus.op1 = '0; bus.op2 = '0; bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        model_hi = '0; model_lo = '0;
    endtask

    task automatic test_multu_max();
        int bc, dc; logic [31:0] h, l;
        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, h, l);
        total++; if (h !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_max_hi got=%h exp=fffffffe", h); end
        total++; if (l !== 32'h0000_0001) begin bad++; $display("FAIL multu_max_lo got=%h exp=00000001", l); end
        total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL multu_done_pulses got=%0d exp=1", dc); end
        model_hi = 32'hFFFF_FFFE; model_lo = 32'h1;
    endtask

    task automatic test_signed();
        int bc, dc; logic [31:0] h, l;
        run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc, h, l);
        total++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
            bad++; $display("FAIL mult_neg got=%h_%h exp=ffffffff_ffffffeb", h, l); end
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc, h, l);
        total++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", h, l); end
        total++; if (dc !== 1) begin bad++; $display("FAIL div_neg_done got=%0d exp=1", dc); end
        model_hi = 32'hFFFF_FFFF; model_lo = 32'hFFFF_FFFD;
    endtask

    task automatic test_div_boundary();
        int bc, dc; logic [31:0] h, l;
        run_op(MDU_DIVU, 32'h1234, 32'h0, bc, dc, h, l);
        total++; if (l !== 32'hFFFF_FFFF || h !== 32'h1234) begin
            bad++; $display("FAIL div_zero got hi=%h lo=%h exp hi=00001234 lo=ffffffff", h, l); end
        total++; if (bc !== 1) begin bad++; $display("FAIL div_zero_busy got=%0d exp=1", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL div_zero_done got=%0d exp=1", dc); end
        run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, h, l);
        total++; if (l !== 32'h8000_0000 || h !== 32'h0) begin
            bad++; $display("FAIL div_intmin got hi=%h lo=%h exp hi=00000000 lo=80000000", h, l); end
        model_hi = 32'h0; model_lo = 32'h8000_0000;
    endtask

    task automatic test_mthi_mtlo();
        int busy_seen, done_seen;
        busy_seen = 0; done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = MDU_MTHI; bus.op1 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        total++; if (bus.hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mthi got=%h exp=deadbeef", bus.hi); end
        if (bus.busy) busy_seen++;
        @(negedge clk);
        bus.mdu_op = MDU_MTLO; bus.op1 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        total++; if (bus.lo !== 32'h0BAD_F00D || bus.hi !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL mtlo got hi=%h lo=%h exp hi=deadbeef lo=0badf00d", bus.hi, bus.lo); end
        if (bus.busy) busy_seen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
            if (bus.done) done_seen++;
        end
        total++; if (busy_seen !== 0) begin bad++; $display("FAIL mt_busy got=%0d exp=0", busy_seen); end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL mt_done got=%0d exp=0", done_seen); end
        model_hi = 32'hDEAD_BEEF; model_lo = 32'h0BAD_F00D;
    endtask

    task automatic test_idle_cancel();
        @(negedge clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.mdu_op = MDU_MTHI; bus.op1 = 32'h1111_2222;
        @(posedge clk); #1;
        total++; if (bus.hi !== model_hi) begin bad++; $display("FAIL idle_cancel_mthi got=%h exp=%h", bus.hi, model_hi); end
        @(negedge clk);
        bus.mdu_op = MDU_MULT; bus.op1 = 32'd3; bus.op2 = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_cancel_mult got busy=%b exp=0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = 3'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        total++; if (bus.busy !== 1'b0 || bus.hi !== model_hi || bus.lo !== model_lo) begin
            bad++; $display("FAIL undef_op got busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                            bus.busy, bus.hi, bus.lo, model_hi, model_lo); end
    endtask

    task automatic test_cancel();
        int dseen, bc, dc; logic [31:0] h, l;
        dseen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = MDU_MULT; bus.op1 = 32'd5; bus.op2 = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL cancel_pre_busy got=%b exp=1", bus.busy); end
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", bus.busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) dseen++;
        end
        total++; if (dseen !== 0) begin bad++; $display("FAIL cancel_done got=%0d exp=0", dseen); end
        total++; if (bus.hi !== model_hi || bus.lo !== model_lo) begin
            bad++; $display("FAIL cancel_hilo got hi=%h lo=%h exp hi=%h lo=%h", bus.hi, bus.lo, model_hi, model_lo); end
        run_op(MDU_MULTU, 32'd2, 32'd3, bc, dc, h, l);
        total++; if (l !== 32'd6 || h !== 32'd0) begin
            bad++; $display("FAIL after_cancel got hi=%h lo=%h exp hi=0 lo=6", h, l); end
        model_hi = 32'd0; model_lo = 32'd6;
    endtask

    task automatic test_async_reset();
        int bc, dc; logic [31:0] h, l;
        @(negedge clk);
        bus.start = 1'b1; bus.mdu_op = MDU_DIVU; bus.op1 = 32'd100; bus.op2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mdu_op = MDU_NOP;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.lo !== 32'h0 || bus.hi !== 32'h0) begin
            bad++; $display("FAIL async_rst_hilo got hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b exp=0", bus.busy); end
        @(negedge clk); rst_n = 1'b1;
        run_op(MDU_DIVU, 32'd100, 32'd7, bc, dc, h, l);
        total++; if (l !== 32'd14 || h !== 32'd2) begin
            bad++; $display("FAIL post_rst_divu got hi=%h lo=%h exp hi=2 lo=14", h, l); end
        model_hi = 32'd2; model_lo = 32'd14;
    endtask

    task automatic test_random();
        int bc, dc, eb; logic [31:0] h, l, eh, el, a, b; logic [2:0] op;
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(1, 4));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 4))
                0: begin a = a & 32'hFFFF; b = b & 32'hFF; end
                1: b = '0;
                2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : b; end
                3: begin a = -(a & 32'hFFF); b = b & 32'h3F; end
                default: ;
            endcase
            model(op, a, b, eh, el, eb);
            if (op == MDU_MULT || op == MDU_MULTU) eb = 33;
            run_op(op, a, b, bc, dc, h, l);
            total++; if (h !== eh || l !== el) begin
                bad++; $display("FAIL rand_result op=%0d a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h",
                                op, a, b, h, l, eh, el); end
            total++; if (bc !== eb || dc !== 1) begin
                bad++; $display("FAIL rand_timing op=%0d b=%h got busy=%0d done=%0d exp busy=%0d done=1",
                                op, b, bc, dc, eb); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        test_reset();
        test_multu_max();
        test_signed();
        test_div_boundary();
        test_mthi_mtlo();
        test_idle_cancel();
        test_cancel();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
